jstk_spi_sequencer: RTL and testbench
=====================================

# jstk_spi_sequencer

Transaction sequencer for the PmodJSTK joystick SPI link. It consumes the half-bit tick derived from the slow serial clock divider and generates SS, SCLK and MOSI, framing one 5-byte read per transaction. It captures the returned position and button data into stable output registers and pulses DONE when a frame completes. It sits between the clock divider and the joystick-to-motor command logic.

## Interface
- SETUP_TICKS, 2, ticks SS is held low before the first SCLK rising edge (1..255)
- GAP_TICKS, 1, idle ticks between bytes, SCLK low, SS low (1..255)
- POLL_TICKS, 3000, ticks from the end of one frame to the auto-start of the next (only with JSTK_AUTOPOLL_EN)
- CLK in 1: system clock
- RST in 1: synchronous, active-high reset
- TICK in 1: one-CLK-cycle pulse per SCLK half-period (edge-detected divider output)
- START in 1: request a transaction; level-sampled in IDLE only
- LED in 2: LED command bits sent in byte 0
- MISO in 1: serial data from the joystick
- SS out 1: slave select, active low
- SCLK out 1: serial clock, SPI mode 0
- MOSI out 1: serial data to the joystick
- BUSY out 1: high from frame start until DONE
- DONE out 1: one-cycle pulse at frame end
- X out 10: X position
- Y out 10: Y position
- BTN out 3: buttons {trigger, btn1, btn0} = byte4[2:0]

## Operation
- Clock and reset: one clock (CLK); RST is synchronous and active-high.
- Reset values: SS=1, SCLK=0, MOSI=0, BUSY=0, DONE=0, X=0, Y=0, BTN=0, state=IDLE, all counters 0.
- States and transitions:
  - IDLE → SETUP when START=1. The transition is taken on any cycle; it is not qualified by TICK.
  - SETUP → SHIFT after SETUP_TICKS ticks.
  - SHIFT → GAP after the 8th falling edge of bytes 0–3.
  - SHIFT → END after the 8th falling edge of byte 4.
  - GAP → SHIFT after GAP_TICKS ticks; the byte index increments.
  - END → IDLE on the next tick.
- Transmit bytes:
  - Byte 0 = {6'b100000, LED}. LED is latched on entry to SETUP.
  - Bytes 1–4 = 8'h00.
  - All bytes are sent MSB first.
  - The MOSI bit for a byte is presented on entry to SHIFT, before the first rising edge.
- SHIFT behaviour:
  - On each tick, SCLK toggles.
  - Low→high: MISO is shifted into the receive register LSB-in.
  - High→low: MOSI advances to the next bit.
- Receive byte mapping:
  - byte0 = X[7:0]
  - byte1[1:0] = X[9:8]
  - byte2 = Y[7:0]
  - byte3[1:0] = Y[9:8]
  - byte4[2:0] = BTN
  - Unused bits are ignored.
- Output update: received bytes go to shadow registers. X, Y and BTN update together, only in the cycle DONE is asserted. There is no partial update.
- START while BUSY=1 is ignored and is not queued.
- RST mid-frame: the frame is aborted and outputs return to reset values on the next edge. X, Y and BTN are cleared and DONE does not pulse.

## Timing
- All outputs are registered.
- START=1 in IDLE at edge n: SS=0 and BUSY=1 from edge n+1.
- Ticks are counted only while TICK=1. Non-tick cycles hold all state except the IDLE→SETUP transition.
- Frame length in ticks = SETUP_TICKS + 5×16 + 4×GAP_TICKS + 1. Default = 87 ticks.
- End of frame, on the END tick edge:
  - SS=1, BUSY=0, DONE=1, and X, Y, BTN are valid.
  - DONE deasserts on the next edge.
- SCLK is low in IDLE, SETUP, GAP and END. SCLK is never high when SS rises.
- A tick coincident with START in IDLE is not counted toward SETUP.
- Back-to-back frames: earliest re-START is sampled in the cycle after DONE.

## Configuration
- JSTK_AUTOPOLL_EN defined:
  - An internal poll counter clears at DONE and counts ticks while in IDLE.
  - At POLL_TICKS it starts a frame as if START were asserted. START is still honoured.
  - The counter resets to 0 on RST.
- JSTK_AUTOPOLL_EN undefined: frames start only on START, and no poll counter is built.

## Test plan
- Reset: hold RST 3 cycles mid-frame → SS=1, SCLK=0, BUSY=0, X=Y=0, BTN=0, and no DONE pulse.
- Basic frame, LED=2'b10, MISO model returns 8'h2A, 8'h03, 8'h10, 8'h02, 8'h05 → MOSI byte0 = 8'h82, then 8'h00 ×4; X=10'h32A, Y=10'h210, BTN=3'b101; DONE exactly once, 87 ticks after START.
- Mode 0 check: every MISO sample occurs on a SCLK rising edge; MOSI is stable across each rising edge; SCLK=0 whenever SS transitions.
- START pulsed 3 times during BUSY → exactly one frame and one DONE.
- TICK every 750 cycles versus every cycle → identical bit sequence and outputs; frame length scales to 87 ticks in both cases.
- With JSTK_AUTOPOLL_EN, POLL_TICKS=10, START held 0 → consecutive frames separated by 10 ticks SS-high; without the macro, no frame starts.

Source files
------------

// File: rtl/jstk_spi_sequencer_if.sv
// Handshake and SPI pin bundle for jstk_spi_sequencer; the sequencer itself uses the slave modport.
interface jstk_spi_sequencer_if;
  logic       tick;
  logic       start;
  logic [1:0] led;
  logic       miso;
  logic       ss;
  logic       sclk;
  logic       mosi;
  logic       busy;
  logic       done;
  logic [9:0] x;
  logic [9:0] y;
  logic [2:0] btn;

  modport master (
    output tick, start, led, miso,
    input  ss, sclk, mosi, busy, done, x, y, btn
  );

  modport slave (
    input  tick, start, led, miso,
    output ss, sclk, mosi, busy, done, x, y, btn
  );
endinterface

// File: rtl/jstk_spi_sequencer.sv
// PmodJSTK 5-byte SPI read sequencer (mode 0), paced by a half-bit tick.
// Optional auto-polling is built when JSTK_AUTOPOLL_EN is defined.
module jstk_spi_sequencer #(
  parameter int unsigned SETUP_TICKS = 2,
  parameter int unsigned GAP_TICKS   = 1
`ifdef JSTK_AUTOPOLL_EN
  , parameter int unsigned POLL_TICKS = 3000
`endif
) (
  input logic                 clk_i,
  input logic                 rst_i,
  jstk_spi_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_END   = 3'd4;

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [2:0] byte_q, byte_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [1:0] led_q, led_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       ss_q, ss_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [9:0] xs_q, xs_d, ys_q, ys_d, x_q, x_d, y_q, y_d;
  logic [2:0] bs_q, bs_d, btn_q, btn_d;
  logic       start_req;

`ifdef JSTK_AUTOPOLL_EN
  localparam int unsigned PW = $clog2(POLL_TICKS + 1);
  logic [PW-1:0] poll_q, poll_d;
  logic          poll_fire;

  // Counter is held at zero outside IDLE, so it restarts from zero at DONE.
  always_comb begin
    poll_fire = (state_q == S_IDLE) && bus.tick && (poll_q == PW'(POLL_TICKS - 1));
    start_req = bus.start | poll_fire;
    poll_d    = '0;
    if (state_q == S_IDLE && !start_req)
      poll_d = bus.tick ? poll_q + 1'b1 : poll_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) poll_q <= '0;
    else       poll_q <= poll_d;
  end
`else
  assign start_req = bus.start;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    led_d   = led_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ss_d    = ss_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    xs_d    = xs_q;
    ys_d    = ys_q;
    bs_d    = bs_q;
    x_d     = x_q;
    y_d     = y_q;
    btn_d   = btn_q;

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          state_d = S_SETUP;
          ss_d    = 1'b0;
          busy_d  = 1'b1;
          led_d   = bus.led;
          cnt_d   = '0;
        end
      end
      S_SETUP: begin
        if (bus.tick) begin
          if (cnt_q == 8'(SETUP_TICKS - 1)) begin
            state_d = S_SHIFT;
            cnt_d   = '0;
            bit_d   = '0;
            byte_d  = '0;
            tx_d    = {6'b100000, led_q};
            mosi_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (bus.tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], bus.miso};
          end else begin
            sclk_d = 1'b0;
            tx_d   = {tx_q[6:0], 1'b0};
            mosi_d = tx_q[6];
            if (bit_q == 3'd7) begin
              bit_d = '0;
              cnt_d = '0;
              case (byte_q)
                3'd0:    xs_d[7:0] = rx_q;
                3'd1:    xs_d[9:8] = rx_q[1:0];
                3'd2:    ys_d[7:0] = rx_q;
                3'd3:    ys_d[9:8] = rx_q[1:0];
                default: bs_d      = rx_q[2:0];
              endcase
              state_d = (byte_q == 3'd4) ? S_END : S_GAP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end
      S_GAP: begin
        if (bus.tick) begin
          if (cnt_q == 8'(GAP_TICKS - 1)) begin
            state_d = S_SHIFT;
            cnt_d   = '0;
            byte_d  = byte_q + 1'b1;
            tx_d    = '0;
            mosi_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_END: begin
        if (bus.tick) begin
          state_d = S_IDLE;
          ss_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          x_d     = xs_q;
          y_d     = ys_q;
          btn_d   = bs_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      led_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      xs_q    <= '0;
      ys_q    <= '0;
      bs_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      btn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      led_q   <= led_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_q    <= ss_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      bs_q    <= bs_d;
      x_q     <= x_d;
      y_q     <= y_d;
      btn_q   <= btn_d;
    end
  end

  assign bus.ss   = ss_q;
  assign bus.sclk = sclk_q;
  assign bus.mosi = mosi_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.x    = x_q;
  assign bus.y    = y_q;
  assign bus.btn  = btn_q;

endmodule

// File: tb/tb_jstk_spi_sequencer.sv
// Directed bench for jstk_spi_sequencer with a mode-0 joystick slave model on MISO.
module tb_jstk_spi_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jstk_spi_sequencer_if bus_if ();

  jstk_spi_sequencer #(
    .SETUP_TICKS(2),
    .GAP_TICKS  (1)
`ifdef JSTK_AUTOPOLL_EN
    , .POLL_TICKS(10)
`endif
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Tick generator: one-cycle pulse every tick_per cycles.
  int tick_per = 1;
  int tick_cnt = 0;
  initial begin
    bus_if.tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_cnt++;
      if (tick_cnt >= tick_per) begin
        tick_cnt = 0;
        bus_if.tick = 1'b1;
      end else begin
        bus_if.tick = 1'b0;
      end
    end
  end

  // Slave model and protocol monitor, sampled 1 time unit after each edge.
  logic [7:0]  rxb [5];
  int          done_cnt = 0, ss_falls = 0, tcount = 0, gap = 0, last_gap = -1;
  int          last_ticks = 0, mode_errs = 0, hold_errs = 0, nbits = 0, last_nbits = 0;
  int          sb_byte = 0, sb_bit = 0;
  logic [39:0] mosi_sh = '0, last_mosi = '0;
  logic [9:0]  last_x = '0, last_y = '0, p_x = '0;
  logic [2:0]  last_btn = '0;
  logic        p_ss = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0, p_busy = 1'b0;

  initial begin
    bus_if.miso = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_if.busy && !p_busy) tcount = 0;
      else if (bus_if.tick)       tcount++;
      if (bus_if.done)                 gap = 0;
      else if (bus_if.tick && p_ss)    gap++;
      if (!rst && bus_if.ss !== p_ss && (bus_if.sclk !== 1'b0 || p_sclk)) mode_errs++;
      if (p_ss && !bus_if.ss) begin
        ss_falls++;
        last_gap = gap;
        sb_byte  = 0;
        sb_bit   = 0;
        nbits    = 0;
        mosi_sh  = '0;
        bus_if.miso = rxb[0][7];
      end
      if (bus_if.sclk && !p_sclk) begin
        if (bus_if.mosi !== p_mosi) mode_errs++;
        mosi_sh = {mosi_sh[38:0], bus_if.mosi};
        nbits++;
      end
      if (!bus_if.sclk && p_sclk) begin
        sb_bit++;
        if (sb_bit == 8) begin
          sb_bit = 0;
          sb_byte++;
        end
        bus_if.miso = (sb_byte < 5) ? rxb[sb_byte][7-sb_bit] : 1'b0;
      end
      if (!rst && !bus_if.done && bus_if.x !== p_x) hold_errs++;
      if (bus_if.done) begin
        done_cnt++;
        last_ticks = tcount;
        last_x     = bus_if.x;
        last_y     = bus_if.y;
        last_btn   = bus_if.btn;
        last_mosi  = mosi_sh;
        last_nbits = nbits;
      end
      p_ss   = bus_if.ss;
      p_sclk = bus_if.sclk;
      p_mosi = bus_if.mosi;
      p_busy = bus_if.busy;
      p_x    = bus_if.x;
    end
  end

  task automatic do_start();
    @(negedge clk);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != d0) break;
    end
    check(tag, done_cnt != d0, 1);
  endtask

  task automatic check_frame(input string tag, input logic [9:0] ex, input logic [9:0] ey,
                             input logic [2:0] eb, input logic [7:0] b0);
    check({tag, "_x"},     last_x, ex);
    check({tag, "_y"},     last_y, ey);
    check({tag, "_btn"},   last_btn, eb);
    check({tag, "_ticks"}, last_ticks, 87);
    check({tag, "_mosi"},  last_mosi, {b0, 32'h0});
    check({tag, "_nbits"}, last_nbits, 40);
  endtask

  int d0, f0;

  initial begin
    bus_if.start = 1'b0;
    bus_if.led   = 2'b00;
    rxb = '{8'h2A, 8'h03, 8'h10, 8'h02, 8'h05};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ss",   bus_if.ss, 1);
    check("rst_sclk", bus_if.sclk, 0);
    check("rst_busy", bus_if.busy, 0);
    check("rst_done", bus_if.done, 0);
    check("rst_xy",   {bus_if.x, bus_if.y, bus_if.btn}, 0);
    rst = 1'b0;

    // Basic frame, tick every cycle.
    bus_if.led = 2'b10;
    do_start();
    check("start_busy", bus_if.busy, 1);
    check("start_ss",   bus_if.ss, 0);
    wait_done("basic_done", 200);
    check_frame("basic", 10'h32A, 10'h210, 3'b101, 8'h82);
    repeat (20) @(negedge clk);
    check("basic_one_done", done_cnt, 1);
    check("basic_idle", {bus_if.ss, bus_if.busy, bus_if.done}, 3'b100);

    // START pulses while busy are dropped.
    rxb = '{8'hFF, 8'hFE, 8'h00, 8'h01, 8'hFA};
    bus_if.led = 2'b01;
    d0 = done_cnt;
    f0 = ss_falls;
    do_start();
    for (int i = 0; i < 3; i++) begin
      repeat (10) @(negedge clk);
      do_start();
    end
    wait_done("busy_done", 200);
    repeat (150) @(negedge clk);
    check("busy_one_done",  done_cnt - d0, 1);
    check("busy_one_frame", ss_falls - f0, 1);
    check_frame("busy", 10'h2FF, 10'h100, 3'b010, 8'h81);

    // Slow tick: same bits and outputs, still 87 ticks.
    tick_per = 750;
    rxb = '{8'h2A, 8'h03, 8'h10, 8'h02, 8'h05};
    bus_if.led = 2'b10;
    do_start();
    wait_done("slow_done", 90 * 750);
    check_frame("slow", 10'h32A, 10'h210, 3'b101, 8'h82);

    // Reset mid-frame.
    tick_per = 2;
    rxb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    do_start();
    repeat (60) @(negedge clk);
    d0 = done_cnt;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mrst_pins", {bus_if.ss, bus_if.sclk, bus_if.busy}, 3'b100);
    check("mrst_xy",   {bus_if.x, bus_if.y, bus_if.btn}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mrst_no_done", done_cnt - d0, 0);

    tick_per = 1;
`ifdef JSTK_AUTOPOLL_EN
    wait_done("poll_done1", 300);
    wait_done("poll_done2", 300);
    repeat (20) @(negedge clk);
    check("poll_gap", last_gap, 10);
`else
    f0 = ss_falls;
    d0 = done_cnt;
    repeat (300) @(negedge clk);
    check("nopoll_frames", ss_falls - f0, 0);
    check("nopoll_done",   done_cnt - d0, 0);
`endif

    check("mode0",      mode_errs, 0);
    check("no_partial", hold_errs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
